// File: rtl/rst_pulse_gen.sv
// Programmable-width active-low reset pulse generator with Busy/Done handshake.
// Define RST_PULSE_HOLDOFF_EN to add a settle window after each pulse before Done.
module rst_pulse_gen #(
    parameter int PULSE_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic Req,
    output logic Soft_RST,
    output logic Busy,
    output logic Done
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);

`ifdef RST_PULSE_HOLDOFF_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             soft_rst_q, soft_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state and next-output logic; Done defaults low so it only ever lasts one cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        soft_rst_d = soft_rst_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Req || pend_q) begin
                    state_d    = ASSERT;
                    cnt_d      = PULSE_LOAD;
                    pend_d     = 1'b0;
                    soft_rst_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    soft_rst_d = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            ASSERT: begin
                // Requests arriving mid-operation, including on the completion edge, merge into one
                pend_d = pend_q || Req;
                if (cnt_q == CNT_ZERO) begin
`ifdef RST_PULSE_HOLDOFF_EN
                    state_d    = HOLDOFF;
                    cnt_d      = HOLD_LOAD;
                    soft_rst_d = 1'b1;
`else
                    state_d    = IDLE;
                    soft_rst_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef RST_PULSE_HOLDOFF_EN
            HOLDOFF: begin
                pend_d = pend_q || Req;
                if (cnt_q == CNT_ZERO) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                cnt_d      = CNT_ZERO;
                pend_d     = 1'b0;
                soft_rst_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State, counter, pending flag and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            cnt_q      <= CNT_ZERO;
            pend_q     <= 1'b0;
            soft_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            soft_rst_q <= soft_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Soft_RST = soft_rst_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Bench for rst_pulse_gen: edge-indexed behavioural model compared every cycle,
// plus directed scenarios with hand-computed pulse/Done counts and positions.
module tb_rst_pulse_gen;

    localparam int P = 4;
    localparam int H = 8;
`ifdef RST_PULSE_HOLDOFF_EN
    localparam int HD = H;
`else
    localparam int HD = 0;
`endif
    localparam int OP = P + HD;   // edges from start to completion

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic Req = 1'b0;
    logic Soft_RST, Busy, Done;

    int checks   = 0;
    int failures = 0;

    rst_pulse_gen #(.PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Req      (Req),
        .Soft_RST (Soft_RST),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation started at edge s owns edges s+1..s+OP; outputs follow from offset n-s
    int   m_n     = 0;
    int   m_start = -1000000;
    int   m_end   = -1000000;
    bit   m_pend  = 1'b0;
    logic e_soft  = 1'b0;
    logic e_busy  = 1'b0;
    logic e_done  = 1'b0;

    initial begin
        int off;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                m_start = -1000000;
                m_end   = -1000000;
                m_pend  = 1'b0;
                e_soft  = 1'b0;
                e_busy  = 1'b0;
                e_done  = 1'b0;
            end else begin
                m_n++;
                if (m_n > m_start && m_n <= m_end) begin
                    if (Req) m_pend = 1'b1;
                end else if (Req || m_pend) begin
                    m_start = m_n;
                    m_end   = m_n + OP;
                    m_pend  = 1'b0;
                end
                off    = m_n - m_start;
                e_soft = !(off >= 0 && off < P);
                e_busy = (off >= 0 && off < OP);
                e_done = (off == OP);
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            check("cyc_soft_rst", int'(Soft_RST), int'(e_soft));
            check("cyc_busy",     int'(Busy),     int'(e_busy));
            check("cyc_done",     int'(Done),     int'(e_done));
        end
    end

    int s_low, s_busy, s_done, s_done_soft;
    int s_fall_edge[$];
    int s_done_edge[$];

    // Drive Req from pat (bit t is sampled at edge k+t) and gather output statistics
    task automatic run(input logic [63:0] pat, input int ncyc);
        logic prev_soft;
        s_low = 0; s_busy = 0; s_done = 0; s_done_soft = 0;
        s_fall_edge.delete();
        s_done_edge.delete();
        prev_soft = Soft_RST;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge CLK);
            if (t > 0) begin
                if (!Soft_RST) s_low++;
                if (Busy) s_busy++;
                if (Done) begin
                    s_done++;
                    s_done_edge.push_back(t - 1);
                    if (Soft_RST) s_done_soft++;
                end
                if (prev_soft && !Soft_RST) s_fall_edge.push_back(t - 1);
                prev_soft = Soft_RST;
            end
            Req = (t < 64) ? pat[t] : 1'b0;
        end
    endtask

    initial begin
        logic [63:0] pat;

        // Power-on
        repeat (3) @(negedge CLK);
        check("por_soft_rst", int'(Soft_RST), 0);
        check("por_busy",     int'(Busy),     0);
        check("por_done",     int'(Done),     0);
        RST = 1'b1;
        @(negedge CLK);
        check("rel_soft_rst", int'(Soft_RST), 1);
        check("rel_busy",     int'(Busy),     0);
        run(64'd0, 3);

        // Single request
        pat = 64'd1;
        run(pat, OP + 6);
        check("s1_low_cycles",  s_low,  P);
        check("s1_busy_cycles", s_busy, OP);
        check("s1_done_count",  s_done, 1);
        check("s1_done_soft_hi", s_done_soft, s_done);
        if (s_done_edge.size() > 0) check("s1_done_edge", s_done_edge[0], OP);
        if (s_fall_edge.size() > 0) check("s1_fall_edge", s_fall_edge[0], 0);

        // Three extra requests during the operation merge into one more pulse
        pat = 64'd1;
        pat[1] = 1'b1;
        pat[OP / 2] = 1'b1;
        pat[OP - 1] = 1'b1;
        run(pat, 2 * OP + 6);
        check("s2_fall_count", s_fall_edge.size(), 2);
        check("s2_done_count", s_done, 2);
        check("s2_low_cycles", s_low,  2 * P);
        if (s_fall_edge.size() > 1) check("s2_fall2_edge", s_fall_edge[1], OP + 1);
        if (s_done_edge.size() > 1) begin
            check("s2_done1_edge", s_done_edge[0], OP);
            check("s2_done2_edge", s_done_edge[1], 2 * OP + 1);
        end

        // Request on the completion edge is kept
        pat = 64'd1;
        pat[OP] = 1'b1;
        run(pat, 2 * OP + 6);
        check("s3_done_count", s_done, 2);
        if (s_fall_edge.size() > 1) check("s3_fall2_edge", s_fall_edge[1], OP + 1);
        else check("s3_fall_count", s_fall_edge.size(), 2);

        // Reset two cycles into the pulse with a pending request
        pat = 64'd3;
        run(pat, 3);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        check("abort_soft_rst", int'(Soft_RST), 0);
        check("abort_busy",     int'(Busy),     0);
        check("abort_done",     int'(Done),     0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        run(64'd0, 3 * OP);
        check("abort_low_cycles",  s_low,  0);
        check("abort_busy_cycles", s_busy, 0);
        check("abort_done_count",  s_done, 0);

        // Req held high: a new pulse every OP+1 edges
        pat = 64'd0;
        for (int i = 0; i <= 2 * (OP + 1); i++) pat[i] = 1'b1;
        run(pat, 3 * (OP + 1) + 6);
        check("hold_fall_count", s_fall_edge.size(), 3);
        check("hold_done_count", s_done, 3);
        check("hold_low_cycles", s_low,  3 * P);
        if (s_fall_edge.size() > 2) begin
            check("hold_period",    s_fall_edge[1] - s_fall_edge[0], OP + 1);
            check("hold_last_fall", s_fall_edge[2], 2 * (OP + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
